// File: rtl/itch_pkg.sv
// Shared ITCH message constants: field widths, message type codes and the
// encoder state encoding used by the order-book-state encoder.
package itch_pkg;

    localparam logic [7:0] MSG_TYPE_ORDER_BOOK_STATE = 8'h4F;

    localparam int TIMESTAMP_BITS     = 32;
    localparam int ORDER_BOOK_ID_BITS = 32;
    localparam int STATE_NAME_BITS    = 160;

    localparam int MSG_BITS_ORDER_BOOK_STATE =
        8 + TIMESTAMP_BITS + ORDER_BOOK_ID_BITS + STATE_NAME_BITS;

    // Largest byte-aligned start offset within a 64-bit word is 56 bits.
    localparam int MAX_OFFSET_BITS = 56;
    localparam int STAGE_BITS      = MAX_OFFSET_BITS + MSG_BITS_ORDER_BOOK_STATE;

    // Fill of the final word when the message starts at bit 0.
    localparam logic [5:0] TRACKER_BASE = 6'(MSG_BITS_ORDER_BOOK_STATE % 64);

    typedef enum logic [0:0] {
        ENC_IDLE = 1'b0,
        ENC_SEND = 1'b1
    } enc_state_e;

endpackage

// File: rtl/order_book_state_encoder.sv
// Packs an order-book-state message behind optional carry bits from the
// previous message and streams it out as 64-bit words with ready/valid flow.
module order_book_state_encoder
    import itch_pkg::*;
#(
    parameter logic [7:0] MSG_TYPE = 8'h4F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  timeStamp,
    input  logic [31:0]  orderBookID,
    input  logic [159:0] stateName,
    input  logic [5:0]   offsetIn,
    input  logic [63:0]  carryIn,
    input  logic         outReady,
    output logic [63:0]  dataOut,
    output logic         dataValid,
    output logic         lastWord,
    output logic [5:0]   trackerOut,
    output logic         busy
);

    enc_state_e r_state;
    enc_state_e w_state_next;

    logic [STAGE_BITS-1:0]                w_stream;
    logic [STAGE_BITS-1:0]                r_stage;
    logic [MSG_BITS_ORDER_BOOK_STATE-1:0] w_msg;
    logic [5:0]                           w_offset;
    logic [63:0]                          w_carry_masked;
    logic [2:0]                           r_word_idx;
    logic [2:0]                           r_last_idx;
    logic [5:0]                           r_tracker;
    logic                                 w_accept_start;
    logic                                 w_word_accept;
    logic                                 w_unused_offset_lsbs;

    // Offsets are byte aligned, so the low three bits carry no information.
    assign w_offset             = {offsetIn[5:3], 3'b000};
    assign w_unused_offset_lsbs = ^offsetIn[2:0];

    assign w_msg          = {stateName, orderBookID, timeStamp, MSG_TYPE};
    assign w_carry_masked = carryIn & ((64'd1 << w_offset) - 64'd1);
    assign w_stream       = ({{MAX_OFFSET_BITS{1'b0}}, w_msg} << w_offset)
                          | {{(STAGE_BITS-64){1'b0}}, w_carry_masked};

    assign dataValid     = (r_state == ENC_SEND);
    assign busy          = (r_state == ENC_SEND);
    assign dataOut       = r_stage[63:0];
    assign lastWord      = dataValid && (r_word_idx == r_last_idx);
    assign trackerOut    = r_tracker;
    assign w_word_accept = dataValid && outReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ENC_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept_start = 1'b0;
        case (r_state)
            ENC_IDLE: begin
                if (start) begin
                    w_accept_start = 1'b1;
                    w_state_next   = ENC_SEND;
                end
            end
            ENC_SEND: begin
                if (w_word_accept && lastWord) begin
                    w_state_next = ENC_IDLE;
                end
            end
            default: w_state_next = ENC_IDLE;
        endcase
    end

    // Staging register: loaded with the whole stream, then drained 64 bits
    // per accepted word so dataOut is always the low word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage    <= '0;
            r_word_idx <= 3'd0;
            r_last_idx <= 3'd0;
            r_tracker  <= 6'd0;
        end else if (w_accept_start) begin
            r_stage    <= w_stream;
            r_word_idx <= 3'd0;
            // Offsets of 32 bits or more push the tail into a fifth word.
            r_last_idx <= offsetIn[5] ? 3'd4 : 3'd3;
            r_tracker  <= w_offset + TRACKER_BASE;
        end else if (w_word_accept) begin
            r_stage    <= r_stage >> 64;
            r_word_idx <= r_word_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_order_book_state_encoder.sv
// Directed self-checking bench for order_book_state_encoder.
module tb_order_book_state_encoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  timeStamp;
    logic [31:0]  orderBookID;
    logic [159:0] stateName;
    logic [5:0]   offsetIn;
    logic [63:0]  carryIn;
    logic         outReady;
    logic [63:0]  dataOut;
    logic         dataValid;
    logic         lastWord;
    logic [5:0]   trackerOut;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] words [0:7];
    logic [7:0]  lasts;
    int          n_words;
    logic        first_valid;
    logic        timed_out;

    localparam logic [159:0] SN_A = 160'h0102030405060708090A0B0C0D0E0F1011121314;
    localparam logic [159:0] SN_B = 160'h5A02030405060708090A0B0C0D0E0F1011121314;

    order_book_state_encoder #(.MSG_TYPE(8'h4F)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .timeStamp   (timeStamp),
        .orderBookID (orderBookID),
        .stateName   (stateName),
        .offsetIn    (offsetIn),
        .carryIn     (carryIn),
        .outReady    (outReady),
        .dataOut     (dataOut),
        .dataValid   (dataValid),
        .lastWord    (lastWord),
        .trackerOut  (trackerOut),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Drives one message with outReady held high and records every accepted
    // word; returns at the falling edge after the final word was accepted.
    task automatic run_msg(input logic [5:0] ofs, input logic [63:0] carry,
                           input logic [159:0] sn);
        logic done;
        done      = 1'b0;
        n_words   = 0;
        lasts     = 8'h00;
        timed_out = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = 64'h0;
        start    = 1'b1;
        offsetIn = ofs;
        carryIn  = carry;
        stateName = sn;
        outReady = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        first_valid = dataValid;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (dataValid && outReady && n_words < 8) begin
                words[n_words] = dataOut;
                lasts[n_words] = lastWord;
                n_words++;
                if (lastWord) done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) timed_out = 1'b1;
        $display("msg offset=%0d words=%0d word0=%h tracker=%0d", ofs, n_words, words[0], trackerOut);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; outReady = 1'b1;
        timeStamp = 32'h11223344; orderBookID = 32'hAABBCCDD;
        stateName = SN_A; offsetIn = 6'd0; carryIn = 64'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({dataValid, busy, lastWord} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {dataValid, busy, lastWord});
        else n_pass++;
        n_total++;
        if (dataOut !== 64'h0 || trackerOut !== 6'd0) $display("FAIL reset_data got=%h/%0d want=0/0", dataOut, trackerOut);
        else n_pass++;
        $display("reset applied");
    endtask

    task automatic test_offset0();
        run_msg(6'd0, 64'hDEAD_BEEF_0000_0000, SN_A);
        n_total++;
        if (timed_out || n_words != 4) $display("FAIL o0_count got=%0d want=4 timeout=%b", n_words, timed_out);
        else n_pass++;
        n_total++;
        if (first_valid !== 1'b1) $display("FAIL o0_latency got=%b want=1", first_valid);
        else n_pass++;
        n_total++;
        if (words[0] !== 64'hBBCCDD112233444F) $display("FAIL o0_word0 got=%h want=BBCCDD112233444F", words[0]);
        else n_pass++;
        n_total++;
        if (words[1] !== 64'h0E0F1011121314AA || words[2] !== 64'h060708090A0B0C0D)
            $display("FAIL o0_word12 got=%h,%h want=0E0F1011121314AA,060708090A0B0C0D", words[1], words[2]);
        else n_pass++;
        n_total++;
        if (words[3] !== 64'h0000000102030405) $display("FAIL o0_word3 got=%h want=0000000102030405", words[3]);
        else n_pass++;
        n_total++;
        if (lasts !== 8'b0000_1000) $display("FAIL o0_last got=%b want=00001000", lasts);
        else n_pass++;
        n_total++;
        if (trackerOut !== 6'd40 || busy !== 1'b0) $display("FAIL o0_tracker got=%0d busy=%b want=40 busy=0", trackerOut, busy);
        else n_pass++;
    endtask

    task automatic test_offset24();
        run_msg(6'd24, 64'hFFFF_FFFF_FFAB_CDEF, SN_A);
        n_total++;
        if (n_words != 4 || lasts !== 8'b0000_1000) $display("FAIL o24_count got=%0d last=%b want=4 last=00001000", n_words, lasts);
        else n_pass++;
        n_total++;
        if (words[0] !== 64'h112233444FABCDEF) $display("FAIL o24_word0 got=%h want=112233444FABCDEF", words[0]);
        else n_pass++;
        n_total++;
        if (words[1] !== 64'h11121314AABBCCDD || words[2] !== 64'h090A0B0C0D0E0F10 || words[3] !== 64'h0102030405060708)
            $display("FAIL o24_words got=%h,%h,%h want=11121314AABBCCDD,090A0B0C0D0E0F10,0102030405060708", words[1], words[2], words[3]);
        else n_pass++;
        n_total++;
        if (trackerOut !== 6'd0) $display("FAIL o24_tracker got=%0d want=0", trackerOut);
        else n_pass++;
    endtask

    task automatic test_offset32();
        // Low offset bits set to confirm they are ignored.
        run_msg(6'd37, 64'h1234_5678_9ABC_DEF0, SN_B);
        n_total++;
        if (n_words != 5 || lasts !== 8'b0001_0000) $display("FAIL o32_count got=%0d last=%b want=5 last=00010000", n_words, lasts);
        else n_pass++;
        n_total++;
        if (words[0] !== 64'h2233444F9ABCDEF0 || words[1] !== 64'h121314AABBCCDD11)
            $display("FAIL o32_word01 got=%h,%h want=2233444F9ABCDEF0,121314AABBCCDD11", words[0], words[1]);
        else n_pass++;
        n_total++;
        if (words[4] !== 64'h000000000000005A) $display("FAIL o32_word4 got=%h want=000000000000005A", words[4]);
        else n_pass++;
        n_total++;
        if (trackerOut !== 6'd8) $display("FAIL o32_tracker got=%0d want=8", trackerOut);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        start = 1'b1; offsetIn = 6'd0; carryIn = 64'h0; stateName = SN_A; outReady = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (dataOut !== 64'h060708090A0B0C0D) $display("FAIL bp_word2 got=%h want=060708090A0B0C0D", dataOut);
        else n_pass++;
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (dataOut !== 64'h060708090A0B0C0D || lastWord !== 1'b0 || dataValid !== 1'b1)
                $display("FAIL bp_hold%0d got=%h last=%b valid=%b want=060708090A0B0C0D last=0 valid=1", i, dataOut, lastWord, dataValid);
            else n_pass++;
        end
        outReady = 1'b1;
        @(negedge clk);
        n_total++;
        if (dataOut !== 64'h0000000102030405 || lastWord !== 1'b1)
            $display("FAIL bp_word3 got=%h last=%b want=0000000102030405 last=1", dataOut, lastWord);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (dataValid !== 1'b0) $display("FAIL bp_end got=%b want=0", dataValid);
        else n_pass++;
        $display("backpressure message done");
    endtask

    task automatic test_start_ignored();
        start = 1'b1; offsetIn = 6'd0; carryIn = 64'h0; stateName = SN_A; outReady = 1'b1;
        @(negedge clk);
        start = 1'b1; offsetIn = 6'd32;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (dataOut !== 64'h0E0F1011121314AA || trackerOut !== 6'd40)
            $display("FAIL busy_start got=%h/%0d want=0E0F1011121314AA/40", dataOut, trackerOut);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (lastWord !== 1'b1 || dataOut !== 64'h0000000102030405)
            $display("FAIL final_word got=%h last=%b want=0000000102030405 last=1", dataOut, lastWord);
        else n_pass++;
        start = 1'b1; offsetIn = 6'd32;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (dataValid !== 1'b0 || busy !== 1'b0 || trackerOut !== 6'd40)
            $display("FAIL final_start got=valid%b busy%b trk%0d want=valid0 busy0 trk40", dataValid, busy, trackerOut);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (dataValid !== 1'b0) $display("FAIL final_start_idle got=%b want=0", dataValid);
        else n_pass++;
        $display("start-ignored message done");
    endtask

    task automatic test_mid_reset();
        start = 1'b1; offsetIn = 6'd0; carryIn = 64'h0; stateName = SN_A; outReady = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; offsetIn = 6'd24;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_total++;
        if (dataValid !== 1'b0 || busy !== 1'b0 || trackerOut !== 6'd0 || dataOut !== 64'h0)
            $display("FAIL midrst got=valid%b busy%b trk%0d data%h want=0,0,0,0", dataValid, busy, trackerOut, dataOut);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (dataValid !== 1'b0) $display("FAIL midrst_start got=%b want=0", dataValid);
        else n_pass++;
        run_msg(6'd24, 64'hFFFF_FFFF_FFAB_CDEF, SN_A);
        n_total++;
        if (n_words != 4 || words[0] !== 64'h112233444FABCDEF)
            $display("FAIL midrst_restart got=%0d/%h want=4/112233444FABCDEF", n_words, words[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_msg(6'd0, 64'h0, SN_A);
        run_msg(6'd32, 64'h1234_5678_9ABC_DEF0, SN_B);
        n_total++;
        if (first_valid !== 1'b1 || n_words != 5 || words[4] !== 64'h5A)
            $display("FAIL b2b got=valid%b n%0d w4=%h want=valid1 n5 w4=5A", first_valid, n_words, words[4]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_offset0();
        test_offset24();
        test_offset32();
        test_backpressure();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/order_book_state_encoder.md
ORDER_BOOK_STATE_ENCODER -- requirements
Module: order_book_state_encoder

Interface
REQ-001 Parameter MSG_TYPE, default 8'h4F, message-type byte emitted ahead of the fields.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request; fields and offset sampled in that cycle.
REQ-005 timeStamp  input  32  message timestamp.
REQ-006 orderBookID  input  32  order book identifier.
REQ-007 stateName  input  160  20-byte state name.
REQ-008 offsetIn  input  6  bit position in the first word where the message starts; bits [2:0] ignored (byte aligned).
REQ-009 carryIn  input  64  preceding-message bits occupying positions below offsetIn of the first word.
REQ-010 outReady  input  1  downstream accepts dataOut this cycle.
REQ-011 dataOut  output  64  packed output word.
REQ-012 dataValid  output  1  dataOut holds a valid word.
REQ-013 lastWord  output  1  current dataOut is the final word of the message.
REQ-014 trackerOut  output  6  bit fill of the final word; 0 means the final word is full.
REQ-015 busy  output  1  message in progress; start ignored.

Function
REQ-016 Message vector M[231:0] = {stateName, orderBookID, timeStamp, MSG_TYPE}; MSG_TYPE at bits [7:0].
REQ-017 Stream S = {M, carryIn[o-1:0]}, o = {offsetIn[5:3],3'b000}; carryIn bits at or above o discarded.
REQ-018 Word k of the message = S[64k+63:64k]; bits of the final word above S length driven 0.
REQ-019 Word count N = ceil((o+232)/64): 4 for o <= 24, 5 for o >= 32.
REQ-020 trackerOut = (o+232) mod 64, registered at start acceptance, held until the next accepted start.
REQ-021 FSM states IDLE, SEND; IDLE -> SEND on start; SEND -> IDLE when the final word is accepted (dataValid & outReady & lastWord).
REQ-022 start accepted only in IDLE; start while busy=1, including the cycle the final word is accepted, is ignored.
REQ-023 Latency: start accepted in cycle t -> word 0 on dataOut with dataValid=1 in cycle t+1.
REQ-024 Word advances only on dataValid & outReady; with outReady=0, dataOut, lastWord held stable.
REQ-025 One accepted word per cycle maximum; no word skipped or repeated.
REQ-026 lastWord=1 exactly on word N-1 while dataValid=1; 0 otherwise.
REQ-027 busy=1 from cycle t+1 through the cycle the final word is accepted.
REQ-028 Internal staging register 288 bits wide (56+232), shifted right by 64 per accepted word.

Reset
REQ-029 rst=1 forces, on the next edge: FSM IDLE, dataOut 0, dataValid 0, lastWord 0, busy 0, trackerOut 0, staging register 0.
REQ-030 rst mid-message abandons the message; no further words emitted; start in the reset cycle ignored.

Structure
REQ-031 Shared package itch_pkg holds MSG_TYPE_ORDER_BOOK_STATE (8'h4F), field widths (32/32/160), MSG_BITS_ORDER_BOOK_STATE (232) and the encoder state encoding.
REQ-032 No sub-module; packing is a single concatenation plus shift register inside this block.

Verification
REQ-033 o=0, TS=32'h11223344, OB=32'hAABBCCDD, outReady=1 -> word0=64'hBBCCDD112233444F, 4 words, lastWord on word 3, trackerOut=40.
REQ-034 offsetIn=24, carryIn=64'hFFFF_FFFF_FFAB_CDEF -> word0[23:0]=24'hABCDEF, word0[31:24]=8'h4F, 4 words, trackerOut=0.
REQ-035 offsetIn=32, stateName[159:152]=8'h5A -> 5 words, word4=64'h5A, trackerOut=8.
REQ-036 outReady=0 for 3 cycles while word 2 presented -> dataOut stable 3 cycles, word 3 follows, total 4 words.
REQ-037 start pulsed during SEND and in the final-acceptance cycle -> both ignored, trackerOut unchanged.
REQ-038 rst asserted after word 1 accepted -> next cycle dataValid=0, busy=0, trackerOut=0; following start emits a complete message from word 0.
